// File: rtl/pe_au_mac_sequencer.sv
// Initiator-side sequencer for one PE_AU: issues N operand pairs, waits out the PE_AU pipeline, returns P.
// Optional abort input is enabled by defining PE_AU_SEQ_ABORT_EN.
module pe_au_mac_sequencer #(
  parameter int N       = 5,
  parameter int LATENCY = 3,
  parameter int A_WIDTH = 27,
  parameter int B_WIDTH = 18,
  parameter int P_WIDTH = 48
) (
  input  logic               clock_i,
  input  logic               reset_n_i,
  input  logic               start_i,
  input  logic [P_WIDTH-1:0] c_i,
`ifdef PE_AU_SEQ_ABORT_EN
  input  logic               abort_i,
`endif
  input  logic               op_valid_i,
  output logic               op_ready_o,
  input  logic [A_WIDTH-1:0] op_a_i,
  input  logic [B_WIDTH-1:0] op_b_i,
  output logic [A_WIDTH-1:0] A_o,
  output logic [B_WIDTH-1:0] B_o,
  output logic [P_WIDTH-1:0] C_o,
  output logic               CREG_en_o,
  output logic [8:0]         OPMODE_o,
  input  logic [P_WIDTH-1:0] P_i,
  output logic               busy_o,
  output logic [P_WIDTH-1:0] result_o,
  output logic               result_valid_o,
  input  logic               result_ready_i
);

  localparam int CW = $clog2(N + 1);
  localparam int DW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] TERM_LAST = CW'(N - 1);
  localparam logic [CW-1:0] TERM_SAT  = CW'(N);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(LATENCY - 1);

  localparam logic [8:0] OPM_ZERO  = 9'b000000000;
  localparam logic [8:0] OPM_FIRST = 9'b000110101;
  localparam logic [8:0] OPM_ACC   = 9'b000100101;
  localparam logic [8:0] OPM_HOLD  = 9'b000100000;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_RESULT} state_t;

  state_t             state_q, state_d;
  logic [A_WIDTH-1:0] a_q, a_d;
  logic [B_WIDTH-1:0] b_q, b_d;
  logic [P_WIDTH-1:0] c_q, c_d;
  logic [P_WIDTH-1:0] result_q, result_d;
  logic [8:0]         opmode_q, opmode_d;
  logic               creg_q, creg_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               rvalid_q, rvalid_d;
  logic [CW-1:0]      term_q, term_d;
  logic [DW-1:0]      drain_q, drain_d;
  logic               abort;

`ifdef PE_AU_SEQ_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    result_d = result_q;
    opmode_d = opmode_q;
    creg_d   = creg_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    rvalid_d = rvalid_q;
    term_d   = term_q;
    drain_d  = drain_q;
    case (state_q)
      S_IDLE: begin
        opmode_d = OPM_ZERO;
        ready_d  = 1'b0;
        creg_d   = 1'b0;
        busy_d   = 1'b0;
        if (start_i) begin
          c_d     = c_i;
          term_d  = '0;
          creg_d  = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (op_valid_i && ready_q) begin
          a_d      = op_a_i;
          b_d      = op_b_i;
          opmode_d = (term_q == '0) ? OPM_FIRST : OPM_ACC;
          term_d   = (term_q == TERM_SAT) ? term_q : term_q + CW'(1);
          if (term_q == TERM_LAST) begin
            ready_d = 1'b0;
            drain_d = '0;
            state_d = S_DRAIN;
          end
        end else begin
          // A bubble must not disturb the partial sum, nor pre-load P before term 0.
          opmode_d = (term_q != '0) ? OPM_HOLD : OPM_ZERO;
        end
      end
      S_DRAIN: begin
        opmode_d = OPM_HOLD;
        if (drain_q == DRAIN_LAST) begin
          result_d = P_i;
          rvalid_d = 1'b1;
          state_d  = S_RESULT;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      S_RESULT: begin
        opmode_d = OPM_HOLD;
        if (result_ready_i) begin
          rvalid_d = 1'b0;
          opmode_d = OPM_ZERO;
          creg_d   = 1'b0;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort wins over any transfer or handshake happening on the same edge.
    if (abort && state_q != S_IDLE) begin
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      opmode_d = OPM_ZERO;
      ready_d  = 1'b0;
      rvalid_d = 1'b0;
      creg_d   = 1'b0;
      busy_d   = 1'b0;
      state_d  = S_IDLE;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      result_q <= '0;
      opmode_q <= OPM_ZERO;
      creg_q   <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      rvalid_q <= 1'b0;
      term_q   <= '0;
      drain_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      result_q <= result_d;
      opmode_q <= opmode_d;
      creg_q   <= creg_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      rvalid_q <= rvalid_d;
      term_q   <= term_d;
      drain_q  <= drain_d;
    end
  end

  assign A_o            = a_q;
  assign B_o            = b_q;
  assign C_o            = c_q;
  assign CREG_en_o      = creg_q;
  assign OPMODE_o       = opmode_q;
  assign op_ready_o     = ready_q;
  assign busy_o         = busy_q;
  assign result_o       = result_q;
  assign result_valid_o = rvalid_q;

endmodule

// File: tb/tb_pe_au_mac_sequencer.sv
// Randomised bench for pe_au_mac_sequencer: two instances (N=3, N=1), each driving a behavioural PE_AU.
module tb_pe_au_mac_sequencer;

  localparam int LAT = 3;
  localparam logic [8:0] ZERO  = 9'b000000000;
  localparam logic [8:0] FIRST = 9'b000110101;
  localparam logic [8:0] ACC   = 9'b000100101;
  localparam logic [8:0] HOLD  = 9'b000100000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        start3 = 1'b0, start1 = 1'b0;
  logic [47:0] c = '0;
  logic        opv = 1'b0;
  logic [26:0] a = '0;
  logic [17:0] b = '0;
  logic        res_rdy = 1'b0;
  logic        abort = 1'b0;

  logic        rdy3, creg3, busy3, rv3, rdy1, creg1, busy1, rv1;
  logic [26:0] a3, a1;
  logic [17:0] b3, b1;
  logic [47:0] c3, c1, res3, res1;
  logic [8:0]  opm3, opm1;
  logic [47:0] p3 = '0, p1 = '0;

  pe_au_mac_sequencer #(.N(3), .LATENCY(LAT), .A_WIDTH(27), .B_WIDTH(18), .P_WIDTH(48)) dut3 (
    .clock_i(clk), .reset_n_i(rst_n), .start_i(start3), .c_i(c),
`ifdef PE_AU_SEQ_ABORT_EN
    .abort_i(abort),
`endif
    .op_valid_i(opv), .op_ready_o(rdy3), .op_a_i(a), .op_b_i(b),
    .A_o(a3), .B_o(b3), .C_o(c3), .CREG_en_o(creg3), .OPMODE_o(opm3), .P_i(p3),
    .busy_o(busy3), .result_o(res3), .result_valid_o(rv3), .result_ready_i(res_rdy));

  pe_au_mac_sequencer #(.N(1), .LATENCY(LAT), .A_WIDTH(27), .B_WIDTH(18), .P_WIDTH(48)) dut1 (
    .clock_i(clk), .reset_n_i(rst_n), .start_i(start1), .c_i(c),
`ifdef PE_AU_SEQ_ABORT_EN
    .abort_i(1'b0),
`endif
    .op_valid_i(opv), .op_ready_o(rdy1), .op_a_i(a), .op_b_i(b),
    .A_o(a1), .B_o(b1), .C_o(c1), .CREG_en_o(creg1), .OPMODE_o(opm1), .P_i(p1),
    .busy_o(busy1), .result_o(res1), .result_valid_o(rv1), .result_ready_i(res_rdy));

  // Behavioural PE_AU: one input register stage then the P register.
  function automatic logic [47:0] pe_f(input logic [8:0] op, input logic [26:0] pa,
                                       input logic [17:0] pb, input logic [47:0] pc,
                                       input logic [47:0] pp);
    case (op)
      FIRST:   return 48'(pa) * 48'(pb) + pc;
      ACC:     return 48'(pa) * 48'(pb) + pp;
      HOLD:    return pp;
      default: return 48'd0;
    endcase
  endfunction

  logic [26:0] s3a = '0, s1a = '0;
  logic [17:0] s3b = '0, s1b = '0;
  logic [47:0] s3c = '0, s1c = '0;
  logic [8:0]  s3o = '0, s1o = '0;
  always @(posedge clk) begin
    s3a <= a3; s3b <= b3; s3c <= c3; s3o <= opm3;
    p3  <= pe_f(s3o, s3a, s3b, s3c, p3);
    s1a <= a1; s1b <= b1; s1c <= c1; s1o <= opm1;
    p1  <= pe_f(s1o, s1a, s1b, s1c, p1);
  end

  logic        sel = 1'b0;
  logic        v_rdy, v_creg, v_busy, v_rv;
  logic [26:0] v_a;
  logic [17:0] v_b;
  logic [47:0] v_c, v_res;
  logic [8:0]  v_opm;
  always_comb begin
    v_rdy = sel ? rdy1 : rdy3;   v_creg = sel ? creg1 : creg3;
    v_busy = sel ? busy1 : busy3; v_rv = sel ? rv1 : rv3;
    v_a = sel ? a1 : a3;         v_b = sel ? b1 : b3;
    v_c = sel ? c1 : c3;         v_res = sel ? res1 : res3;
    v_opm = sel ? opm1 : opm3;
  end

  int n_chk = 0;
  int n_fail = 0;
  logic [26:0] ta [3];
  logic [17:0] tb [3];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input logic v);
    if (sel) start1 = v; else start3 = v;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, v_busy, 0);
    check({tag, "_rv"}, v_rv, 0);
    check({tag, "_rdy"}, v_rdy, 0);
    check({tag, "_creg"}, v_creg, 0);
    check({tag, "_opm"}, v_opm, ZERO);
  endtask

  // One complete operation; expected result is C plus the sum of products, modulo 2^48.
  task automatic run_op(input bit s, input int n, input logic [47:0] cv, input int max_bub,
                        input int rdy_dly, input bit poke);
    logic [47:0] exp_r;
    logic [47:0] held;
    int lat;
    sel = s;
    exp_r = cv;
    for (int i = 0; i < n; i++) exp_r = exp_r + 48'(ta[i]) * 48'(tb[i]);
    res_rdy = (rdy_dly == 0);
    c = cv;
    set_start(1'b1);
    tick();
    set_start(1'b0);
    check("start_busy", v_busy, 1);
    check("start_rdy", v_rdy, 1);
    check("start_creg", v_creg, 1);
    check("start_c", v_c, cv);
    check("start_opm", v_opm, ZERO);
    for (int i = 0; i < n; i++) begin
      int bub;
      bub = $urandom_range(max_bub, 0);
      repeat (bub) begin
        opv = 1'b0; a = 27'($urandom); b = 18'($urandom);
        tick();
        check("bub_opm", v_opm, (i > 0) ? HOLD : ZERO);
        if (i > 0) check("bub_a", v_a, ta[i-1]);
      end
      opv = 1'b1; a = ta[i]; b = tb[i];
      check("xfer_rdy", v_rdy, 1);
      tick();
      opv = 1'b0; a = 27'($urandom); b = 18'($urandom);
      check("xfer_a", v_a, ta[i]);
      check("xfer_b", v_b, tb[i]);
      check("xfer_opm", v_opm, (i == 0) ? FIRST : ACC);
    end
    check("last_rdy", v_rdy, 0);
    lat = 0;
    do begin
      tick();
      lat++;
      if (!v_rv) check("drain_opm", v_opm, HOLD);
    end while (!v_rv && lat < 20);
    check("latency", lat, LAT);
    check("result", v_res, exp_r);
    check("res_opm", v_opm, HOLD);
    check("res_busy", v_busy, 1);
    held = v_res;
    repeat (rdy_dly) begin
      set_start(poke);
      tick();
      set_start(1'b0);
      check("bp_rv", v_rv, 1);
      check("bp_res", v_res, held);
      check("bp_opm", v_opm, HOLD);
    end
    res_rdy = 1'b1;
    set_start(poke);
    tick();
    set_start(1'b0);
    res_rdy = 1'b0;
    check_idle("done");
    tick();
    check("no_restart", v_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      check_idle("rst");
      check("rst_a", v_a, 0);
      check("rst_b", v_b, 0);
      check("rst_c", v_c, 0);
      check("rst_res", v_res, 0);
    end
    rst_n = 1'b1;
    tick();

    // Basic: back-to-back, ready already high.
    ta[0] = 2; tb[0] = 3; ta[1] = 4; tb[1] = 5; ta[2] = 6; tb[2] = 7;
    run_op(0, 3, 48'h10, 0, 0, 0);
    // Bubbles between pairs.
    run_op(0, 3, 48'h10, 2, 0, 0);
    // Single term with backpressure and ignored start pulses.
    ta[0] = 27'h55387d3; tb[0] = 18'h128ea;
    run_op(1, 1, 48'h0, 0, 5, 1);

    // Reset during DRAIN abandons the operation.
    sel = 0; c = 48'h5;
    start3 = 1'b1; tick(); start3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      opv = 1'b1; a = 27'(i + 1); b = 18'd2; tick();
    end
    opv = 1'b0;
    tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check_idle("midrst");
    check("midrst_a", v_a, 0);
    check("midrst_c", v_c, 0);
    repeat (6) begin
      tick();
      check("midrst_rv", v_rv, 0);
    end
    for (int i = 0; i < 3; i++) begin ta[i] = 1; tb[i] = 1; end
    run_op(0, 3, 48'h1, 1, 1, 0);

`ifdef PE_AU_SEQ_ABORT_EN
    sel = 0; c = 48'h10;
    start3 = 1'b1; tick(); start3 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      opv = 1'b1; a = 27'(2 * i + 2); b = 18'(2 * i + 3); tick();
    end
    opv = 1'b1; a = 27'd6; b = 18'd7; abort = 1'b1;
    tick();
    opv = 1'b0; abort = 1'b0;
    check_idle("abort");
    repeat (6) begin
      tick();
      check("abort_rv", v_rv, 0);
    end
    ta[0] = 2; tb[0] = 3; ta[1] = 4; tb[1] = 5; ta[2] = 6; tb[2] = 7;
    run_op(0, 3, 48'h10, 0, 0, 0);
`endif

    // Randomised operations on both instances.
    for (int it = 0; it < 16; it++) begin
      bit s;
      s = it[0];
      for (int i = 0; i < 3; i++) begin
        ta[i] = 27'($urandom);
        tb[i] = 18'($urandom);
      end
      run_op(s, s ? 1 : 3, {16'($urandom), 32'($urandom)}, 3, $urandom_range(3, 0), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
